alu_result_bcd: RTL and testbench



---
 rtl/alu_result_bcd_pkg.sv | 30 +++
 rtl/alu_result_bcd_if.sv | 28 ++
 rtl/alu_result_bcd_digit_adjust.sv | 15 +
 rtl/alu_result_bcd.sv | 137 +++++++++++++
 tb/tb_alu_result_bcd.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_bcd_pkg.sv
// Shared definitions for the ALU result binary-to-BCD display stage.
//   state_t         : converter state encoding
//   BCD_ADJ_*       : shift-add-3 digit correction constants
//   cnt_width()     : width of the bit counter for a given input width
//   pow10()         : 10^n, used to check that DIGITS covers the input range
package alu_result_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_result_bcd_if.sv
// Handshake bundle for alu_result_bcd.
//   in_valid/in_ready/in_data : binary value from the ALU
//   out_valid/out_ready       : completed-conversion handshake
//   bcd                       : digit k in bits [4k+3:4k], digit 0 = ones
//   blank                     : per-digit leading-zero flags
// slave is the converter side, master is the producer/consumer side.
interface alu_result_bcd_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, bcd, blank
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, bcd, blank
    );
endinterface

// File: rtl/alu_result_bcd_digit_adjust.sv
// One BCD digit correction step of the shift-add-3 conversion.
//   digit_in  : current accumulator digit
//   digit_out : digit_in + 3 when digit_in >= 5, else digit_in
// The +3 stays within 4 bits; the shift that follows carries the overflow
// into the next digit.
module bcd_digit_adjust
    import alu_result_bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD) : digit_in;

endmodule

// File: rtl/alu_result_bcd.sv
// Sequential binary-to-BCD converter for the ALU result display path.
// One input bit is consumed per clock; the finished digits and their
// leading-zero blank flags are held until the next conversion completes.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : alu_result_bcd_if.slave (input and output handshakes, bcd, blank)
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | in_ready high, waiting for in_valid
//   SHIFT | one shift-add-3 step per clock, cnt counts down
//   DONE  | out_valid high, bcd/blank held until out_ready
module alu_result_bcd
    import alu_result_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    alu_result_bcd_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    generate
        if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_params
            $error("alu_result_bcd: DIGITS too small to hold 2^WIDTH-1");
        end
    endgenerate

    state_t                state_q;
    state_t                state_d;
    logic [WIDTH-1:0]      bin_q;
    logic [WIDTH-1:0]      bin_shift;
    logic [4*DIGITS-1:0]   acc_q;
    logic [4*DIGITS-1:0]   acc_adj;
    logic [4*DIGITS-1:0]   acc_shift;
    logic [CW-1:0]         cnt_q;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [DIGITS-1:0]     blank_q;
    logic [DIGITS-1:0]     blank_d;
    logic                  last_step;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (acc_q[4*g +: 4]),
            .digit_out (acc_adj[4*g +: 4])
        );
    end

    // Correct every digit, then shift the whole {accumulator, binary} pair.
    assign {acc_shift, bin_shift} = {acc_adj, bin_q} << 1;

    assign last_step = (cnt_q == CW'(1));

    // Blanking ripples down from the top digit; the ones digit always shows.
    always_comb begin
        blank_d = '0;
        blank_d[DIGITS-1] = (acc_shift[4*(DIGITS-1) +: 4] == 4'd0);
        for (int k = DIGITS - 2; k >= 1; k--) begin
            blank_d[k] = blank_d[k+1] & (acc_shift[4*k +: 4] == 4'd0);
        end
        blank_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            blank_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin_q <= bus.in_data;
                        acc_q <= '0;
                        cnt_q <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    bin_q <= bin_shift;
                    acc_q <= acc_shift;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_step) begin
                        bcd_q   <= acc_shift;
                        blank_q <= blank_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bcd   = bcd_q;
    assign bus.blank = blank_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed-vector bench for alu_result_bcd: an 8-bit/3-digit instance and a
// 4-bit/2-digit instance, expected digits and blank flags computed by hand.
module tb_alu_result_bcd;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    alu_result_bcd_if #(.WIDTH(8), .DIGITS(3)) a ();
    alu_result_bcd_if #(.WIDTH(4), .DIGITS(2)) b ();

    alu_result_bcd #(.WIDTH(8), .DIGITS(3)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (a.slave)
    );

    alu_result_bcd #(.WIDTH(4), .DIGITS(2)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b.slave)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle_a();
        int k = 0;
        while (!a.in_ready && k < 50) begin
            @(posedge clock); #1;
            k++;
        end
    endtask

    // Wait for out_valid; lat counts cycles after the acceptance edge.
    task automatic wait_out_a(output int lat, output bit ir_seen);
        lat = 0;
        ir_seen = 1'b0;
        while (!a.out_valid && lat < 50) begin
            if (a.in_ready) ir_seen = 1'b1;
            @(posedge clock); #1;
            lat++;
        end
        if (a.in_ready) ir_seen = 1'b1;
    endtask

    task automatic send_a(input string tag, input logic [7:0] v,
                          input logic [11:0] exp_bcd, input logic [2:0] exp_blank);
        int lat;
        bit ir_seen;
        wait_idle_a();
        a.in_data  = v;
        a.in_valid = 1'b1;
        @(posedge clock); #1;
        a.in_valid = 1'b0;
        wait_out_a(lat, ir_seen);
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_bcd"}, a.bcd, exp_bcd);
        chk({tag, "_blank"}, a.blank, exp_blank);
        chk({tag, "_ready_low"}, ir_seen, 0);
        a.out_ready = 1'b1;
        @(posedge clock); #1;
        a.out_ready = 1'b0;
        chk({tag, "_vld_drop"}, a.out_valid, 0);
        chk({tag, "_rdy_back"}, a.in_ready, 1);
        chk({tag, "_bcd_hold"}, a.bcd, exp_bcd);
    endtask

    task automatic send_b(input string tag, input logic [3:0] v,
                          input logic [7:0] exp_bcd, input logic [1:0] exp_blank);
        int lat = 0;
        int k = 0;
        while (!b.in_ready && k < 50) begin
            @(posedge clock); #1;
            k++;
        end
        b.in_data  = v;
        b.in_valid = 1'b1;
        @(posedge clock); #1;
        b.in_valid = 1'b0;
        while (!b.out_valid && lat < 50) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_bcd"}, b.bcd, exp_bcd);
        chk({tag, "_blank"}, b.blank, exp_blank);
        b.out_ready = 1'b1;
        @(posedge clock); #1;
        b.out_ready = 1'b0;
        chk({tag, "_vld_drop"}, b.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit ir_seen;
        bit stable;
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", a.in_ready, 1);
        chk("rst_out_valid", a.out_valid, 0);
        chk("rst_bcd", a.bcd, 12'h000);
        chk("rst_blank", a.blank, 3'b000);
        #10 reset_n = 1'b1;
        @(posedge clock); #1;

        // 1, 2: zero and full-scale
        send_a("zero", 8'd0,   12'h000, 3'b110);
        send_a("max",  8'd255, 12'h255, 3'b000);

        // 3: back-to-back 15 then 100 with out_ready held high
        wait_idle_a();
        a.out_ready = 1'b1;
        a.in_data   = 8'd15;
        a.in_valid  = 1'b1;
        @(posedge clock); #1;
        a.in_data   = 8'd100;
        wait_out_a(lat, ir_seen);
        chk("b2b_15_lat", lat, 8);
        chk("b2b_15_bcd", a.bcd, 12'h015);
        chk("b2b_15_blank", a.blank, 3'b100);
        chk("b2b_15_ready_low", ir_seen, 0);
        @(posedge clock); #1;
        chk("b2b_idle_ready", a.in_ready, 1);
        @(posedge clock); #1;
        a.in_valid = 1'b0;
        chk("b2b_100_accepted", a.in_ready, 0);
        wait_out_a(lat, ir_seen);
        chk("b2b_100_lat", lat, 8);
        chk("b2b_100_bcd", a.bcd, 12'h100);
        chk("b2b_100_blank", a.blank, 3'b000);
        @(posedge clock); #1;
        a.out_ready = 1'b0;
        chk("b2b_100_done", a.out_valid, 0);

        // 4: backpressure while in_valid toggles with 77
        wait_idle_a();
        a.in_data  = 8'd9;
        a.in_valid = 1'b1;
        @(posedge clock); #1;
        a.in_valid = 1'b0;
        wait_out_a(lat, ir_seen);
        chk("bp_9_bcd", a.bcd, 12'h009);
        chk("bp_9_blank", a.blank, 3'b110);
        a.in_data = 8'd77;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a.in_valid = ~a.in_valid;
            @(posedge clock); #1;
            if (a.bcd !== 12'h009 || a.blank !== 3'b110 || a.out_valid !== 1'b1 || a.in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        a.in_valid  = 1'b1;
        a.out_ready = 1'b1;
        @(posedge clock); #1;
        a.out_ready = 1'b0;
        chk("bp_idle_ready", a.in_ready, 1);
        chk("bp_bcd_kept", a.bcd, 12'h009);
        @(posedge clock); #1;
        a.in_valid = 1'b0;
        wait_out_a(lat, ir_seen);
        chk("bp_77_lat", lat, 8);
        chk("bp_77_bcd", a.bcd, 12'h077);
        chk("bp_77_blank", a.blank, 3'b100);
        a.out_ready = 1'b1;
        @(posedge clock); #1;
        a.out_ready = 1'b0;

        // 5: asynchronous reset after 3 shift cycles of 200
        wait_idle_a();
        a.in_data  = 8'd200;
        a.in_valid = 1'b1;
        @(posedge clock); #1;
        a.in_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", a.out_valid, 0);
        chk("mid_rst_bcd", a.bcd, 12'h000);
        #1 reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", a.in_ready, 1);
        chk("post_rst_out_valid", a.out_valid, 0);
        chk("post_rst_bcd", a.bcd, 12'h000);
        chk("post_rst_blank", a.blank, 3'b000);
        send_a("fresh42", 8'd42, 12'h042, 3'b100);

        // 6: narrow variant
        send_b("w4_15", 4'd15, 8'h15, 2'b00);
        send_b("w4_7",  4'd7,  8'h07, 2'b10);
        send_b("w4_0",  4'd0,  8'h00, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
